// File: rtl/i2c_eeprom_slave_if.sv
// I2C pin bundle between a bus master (or pad model) and the EEPROM slave.
// sda_oe is the slave's open-drain pull-down request; the pad resolves the wired-AND.
interface i2c_eeprom_slave_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// 24C16-style I2C EEPROM slave: oversampled SCL/SDA, 1/2-byte word addressing,
// page-wrapped writes, sequential reads, write protect and busy/ACK polling.
module i2c_eeprom_slave #(
  parameter int         ADDR_W     = 11,
  parameter int         ADDR_BYTES = 1,
  parameter logic [2:0] HW_ADDR    = 3'b000,
  parameter int         PAGE_SIZE  = 16,
  parameter int         WR_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  i2c_eeprom_slave_if.slave i2c,
  input  logic              wp,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(WR_CYCLES + 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] LO_MASK   = ADDR_W'(8'hFF);

  typedef enum logic [3:0] {
    IDLE, CTRL, CTRL_ACK, ADDR_HI, ADDR_LO, ADDR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_scl_sync, r_sda_sync;
  logic               r_scl_d, r_sda_d;
  logic [3:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
  logic               r_sda_oe, w_sda_oe_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_lo_pending, w_lo_pending_nxt;
  logic               w_mem_we;
  logic               r_wrote;
  logic               r_busy;
  logic [CNT_W-1:0]   r_busy_cnt;

  // NOTE: memory is deliberately left out of reset so it maps onto RAM; contents survive rst.
  logic [7:0] r_mem [DEPTH] = '{default: 8'hFF};

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_ctrl_match;
  logic [7:0]        w_byte, w_rd_byte;
  logic [ADDR_W-1:0] w_ptr_page, w_ptr_lin;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_mem[r_ptr];
  assign w_ptr_lin  = r_ptr + ADDR_W'(1);
  assign w_ptr_page = (r_ptr & ~PAGE_MASK) | (w_ptr_lin & PAGE_MASK);
  assign w_ctrl_match = (ADDR_BYTES == 2) ? (r_shift[7:1] == {4'b1010, HW_ADDR})
                                          : (r_shift[7:4] == 4'b1010);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i2c.scl_i};
      r_sda_sync <= {r_sda_sync[0], i2c.sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_ptr_nxt        = r_ptr;
    w_sda_oe_nxt     = r_sda_oe;
    w_rw_nxt         = r_rw;
    w_lo_pending_nxt = r_lo_pending;
    w_mem_we         = 1'b0;
    if (w_stop) begin
      w_state_nxt   = IDLE;
      w_bit_cnt_nxt = 4'd0;
      w_sda_oe_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = CTRL;
      w_bit_cnt_nxt = 4'd0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      case (r_state)
        CTRL, ADDR_HI, ADDR_LO, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_state == WDATA && r_bit_cnt == 4'd7) begin
              w_mem_we  = ~wp;
              w_ptr_nxt = w_ptr_page;
            end
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b1;
            case (r_state)
              CTRL: begin
                if (w_ctrl_match && !r_busy) begin
                  w_state_nxt = CTRL_ACK;
                  w_rw_nxt    = r_shift[0];
                  if (ADDR_BYTES == 1)
                    w_ptr_nxt = ADDR_W'({r_shift[3:1], 8'h00}) | (r_ptr & LO_MASK);
                end else begin
                  w_state_nxt  = IDLE;
                  w_sda_oe_nxt = 1'b0;
                end
              end
              ADDR_HI: begin
                w_state_nxt      = ADDR_ACK;
                w_lo_pending_nxt = 1'b1;
                w_ptr_nxt        = ADDR_W'({r_shift, 8'h00}) | (r_ptr & LO_MASK);
              end
              ADDR_LO: begin
                w_state_nxt      = ADDR_ACK;
                w_lo_pending_nxt = 1'b0;
                w_ptr_nxt        = (r_ptr & ~LO_MASK) | ADDR_W'(r_shift);
              end
              default: w_state_nxt = WDATA_ACK;
            endcase
          end
        end
        CTRL_ACK, RDATA_ACK: begin
          if (r_state == RDATA_ACK && w_scl_rise && w_sda) begin
            w_state_nxt = IDLE;
          end else if (w_scl_fall) begin
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            if (r_rw) begin
              // Launch the MSB of the next read byte on the same falling edge.
              w_state_nxt  = RDATA;
              w_shift_nxt  = w_rd_byte;
              w_sda_oe_nxt = ~w_rd_byte[7];
              w_ptr_nxt    = w_ptr_lin;
            end else begin
              w_state_nxt = (ADDR_BYTES == 2) ? ADDR_HI : ADDR_LO;
            end
          end
        end
        ADDR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
            w_state_nxt   = (r_state == ADDR_ACK && r_lo_pending) ? ADDR_LO : WDATA;
          end
        end
        RDATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_nxt  = RDATA_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'h00;
      r_ptr        <= '0;
      r_sda_oe     <= 1'b0;
      r_rw         <= 1'b0;
      r_lo_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_ptr        <= w_ptr_nxt;
      r_sda_oe     <= w_sda_oe_nxt;
      r_rw         <= w_rw_nxt;
      r_lo_pending <= w_lo_pending_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  // Busy only follows a STOP that closes a transaction which actually stored data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrote    <= 1'b0;
      r_busy     <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      if (w_mem_we) r_wrote <= 1'b1;
      else if (w_stop) r_wrote <= 1'b0;
      if (w_stop && r_wrote) begin
        r_busy     <= 1'b1;
        r_busy_cnt <= CNT_W'(WR_CYCLES - 1);
      end else if (r_busy) begin
        if (r_busy_cnt == '0) r_busy <= 1'b0;
        else r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
    end
  end

  assign i2c.sda_oe = r_sda_oe;
  assign busy       = r_busy;
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: a bit-banged I2C master drives two
// instances (1-byte addressing and 2-byte addressing with HW_ADDR=101).
module tb_i2c_eeprom_slave;
  localparam int Q      = 8;
  localparam int WR_CYC = 1000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sel   = 1'b0;
  logic wp_a  = 1'b0;
  logic wp_b  = 1'b0;
  logic busy_a, busy_b;
  logic w_sda_line;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cyc = 0;
  logic busy_clr = 1'b1;

  i2c_eeprom_slave_if bus_a ();
  i2c_eeprom_slave_if bus_b ();

  always #5 clk = ~clk;

  assign w_sda_line  = m_sda & ~(sel ? bus_b.sda_oe : bus_a.sda_oe);
  assign bus_a.scl_i = sel ? 1'b1 : m_scl;
  assign bus_a.sda_i = sel ? 1'b1 : w_sda_line;
  assign bus_b.scl_i = sel ? m_scl : 1'b1;
  assign bus_b.sda_i = sel ? w_sda_line : 1'b1;

  i2c_eeprom_slave #(.ADDR_W(11), .ADDR_BYTES(1), .HW_ADDR(3'b000),
                     .PAGE_SIZE(16), .WR_CYCLES(WR_CYC)) dut_a (
    .clk(clk), .rst(rst), .i2c(bus_a), .wp(wp_a), .busy(busy_a));

  i2c_eeprom_slave #(.ADDR_W(11), .ADDR_BYTES(2), .HW_ADDR(3'b101),
                     .PAGE_SIZE(16), .WR_CYCLES(WR_CYC)) dut_b (
    .clk(clk), .rst(rst), .i2c(bus_b), .wp(wp_b), .busy(busy_b));

  always @(negedge clk) begin
    if (busy_clr) busy_cyc = 0;
    else if (sel ? busy_b : busy_a) busy_cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(2 * Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    b = w_sda_line; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic send_chk(input string tag, input logic [7:0] d, input logic exp_ack);
    logic ack;
    send_byte(d, ack);
    check(tag, ack, exp_ack);
  endtask

  task automatic wait_busy_low(input string tag);
    int t = 0;
    while ((sel ? busy_b : busy_a) && t < 3 * WR_CYC) begin
      tick(1);
      t++;
    end
    check(tag, sel ? busy_b : busy_a, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       ack;
    int         n_ack;
    logic [7:0] exp_d;

    // Reset state
    tick(4);
    check("rst oe_a", bus_a.sda_oe, 1'b0);
    check("rst busy_a", busy_a, 1'b0);
    check("rst oe_b", bus_b.sda_oe, 1'b0);
    check("rst busy_b", busy_b, 1'b0);
    rst = 1'b0;
    tick(4);

    // Byte write to 0x25C, busy length, random read back
    i2c_start;
    send_chk("t1 ctrl ack", 8'hA4, 1'b1);
    send_chk("t1 addr ack", 8'h5C, 1'b1);
    send_chk("t1 data ack", 8'h3E, 1'b1);
    busy_clr = 1'b0;
    i2c_stop;
    wait_busy_low("t1 busy fall");
    check("t1 busy cycles", busy_cyc, WR_CYC);
    busy_clr = 1'b1;
    i2c_start;
    send_chk("t1 rd ctrl ack", 8'hA4, 1'b1);
    send_chk("t1 rd addr ack", 8'h5C, 1'b1);
    i2c_start;
    send_chk("t1 rd ctrl2 ack", 8'hA5, 1'b1);
    recv_byte(d, 1'b0);
    check("t1 rd data", d, 8'h3E);
    i2c_stop;
    tick(8);
    check("t1 addr-only no busy", busy_a, 1'b0);

    // Page-wrapped write of 17 bytes at 0x0F0
    n_ack = 0;
    i2c_start;
    send_byte(8'hA0, ack); n_ack += int'(ack);
    send_byte(8'hF0, ack); n_ack += int'(ack);
    for (int i = 0; i <= 16; i++) begin
      send_byte(8'(i), ack);
      n_ack += int'(ack);
    end
    i2c_stop;
    check("t2 acks", n_ack, 19);
    check("t2 busy set", busy_a, 1'b1);

    // ACK polling while busy, then after busy drops
    i2c_start;
    send_chk("t3 poll nack", 8'hA0, 1'b0);
    i2c_stop;
    wait_busy_low("t3 busy fall");
    i2c_start;
    send_chk("t3 poll ack", 8'hA0, 1'b1);
    send_chk("t3 addr ack", 8'hF0, 1'b1);
    i2c_start;
    send_chk("t3 rd ctrl ack", 8'hA1, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      recv_byte(d, i < 16);
      exp_d = (i == 0) ? 8'h10 : ((i == 16) ? 8'hFF : 8'(i));
      check($sformatf("t2 page rd[%0d]", i), d, exp_d);
    end
    i2c_stop;

    // Sequential read across the top of memory
    i2c_start;
    send_chk("t4 w1 ctrl", 8'hAE, 1'b1);
    send_chk("t4 w1 addr", 8'hFF, 1'b1);
    send_chk("t4 w1 data", 8'hAB, 1'b1);
    i2c_stop;
    wait_busy_low("t4 w1 busy");
    i2c_start;
    send_chk("t4 w2 ctrl", 8'hA0, 1'b1);
    send_chk("t4 w2 addr", 8'h00, 1'b1);
    send_chk("t4 w2 d0", 8'hC1, 1'b1);
    send_chk("t4 w2 d1", 8'hC2, 1'b1);
    i2c_stop;
    wait_busy_low("t4 w2 busy");
    i2c_start;
    send_chk("t4 rd ctrl", 8'hAE, 1'b1);
    send_chk("t4 rd addr", 8'hFF, 1'b1);
    i2c_start;
    send_chk("t4 rd ctrl2", 8'hAF, 1'b1);
    recv_byte(d, 1'b1);
    check("t4 rd 7FF", d, 8'hAB);
    recv_byte(d, 1'b1);
    check("t4 rd 000", d, 8'hC1);
    recv_byte(d, 1'b0);
    check("t4 rd 001", d, 8'hC2);
    check("t4 nack released", bus_a.sda_oe, 1'b0);
    i2c_stop;

    // Two-byte addressing instance, HW_ADDR=101, write protect
    sel = 1'b1;
    tick(8);
    i2c_start;
    send_chk("t5 AA ack", 8'hAA, 1'b1);
    i2c_stop;
    i2c_start;
    send_chk("t5 A0 nack", 8'hA0, 1'b0);
    i2c_stop;
    wp_b = 1'b1;
    i2c_start;
    send_chk("t5 wp ctrl", 8'hAA, 1'b1);
    send_chk("t5 wp hi", 8'h00, 1'b1);
    send_chk("t5 wp lo", 8'h10, 1'b1);
    send_chk("t5 wp data", 8'h77, 1'b1);
    i2c_stop;
    tick(20);
    check("t5 wp no busy", busy_b, 1'b0);
    wp_b = 1'b0;
    i2c_start;
    send_chk("t5 w ctrl", 8'hAA, 1'b1);
    send_chk("t5 w hi", 8'h00, 1'b1);
    send_chk("t5 w lo", 8'h11, 1'b1);
    send_chk("t5 w data", 8'h55, 1'b1);
    i2c_stop;
    check("t5 busy set", busy_b, 1'b1);
    wait_busy_low("t5 busy fall");
    i2c_start;
    send_chk("t5 rd ctrl", 8'hAA, 1'b1);
    send_chk("t5 rd hi", 8'h00, 1'b1);
    send_chk("t5 rd lo", 8'h10, 1'b1);
    i2c_start;
    send_chk("t5 rd ctrl2", 8'hAB, 1'b1);
    recv_byte(d, 1'b1);
    check("t5 rd 0010", d, 8'hFF);
    recv_byte(d, 1'b0);
    check("t5 rd 0011", d, 8'h55);
    i2c_stop;

    // Reset in the middle of a read while the slave pulls SDA low
    sel = 1'b0;
    tick(8);
    i2c_start;
    send_chk("t6 ctrl", 8'hA0, 1'b1);
    send_chk("t6 addr", 8'h00, 1'b1);
    i2c_start;
    send_chk("t6 rd ctrl", 8'hA1, 1'b1);
    get_bit(ack);
    get_bit(ack);
    check("t6 pre oe", bus_a.sda_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    check("t6 rst oe", bus_a.sda_oe, 1'b0);
    rst = 1'b0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(4 * Q);
    i2c_start;
    send_chk("t6 post ctrl", 8'hA0, 1'b1);
    send_chk("t6 post addr", 8'h01, 1'b1);
    i2c_start;
    send_chk("t6 post rd ctrl", 8'hA1, 1'b1);
    recv_byte(d, 1'b0);
    check("t6 post rd 001", d, 8'hC2);
    i2c_stop;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
